// File: rtl/clavier_pkg.sv
// clavier_pkg: set-2 scancode constants and the make-code to character translation.
package clavier_pkg;
    localparam logic [7:0] TOUCHE_ENTREE = 8'd128;
    localparam logic [7:0] TOUCHE_RETOUR = 8'd129;
    localparam logic [7:0] TOUCHE_GAUCHE = 8'd130;
    localparam logic [7:0] TOUCHE_HAUT = 8'd131;
    localparam logic [7:0] TOUCHE_DROITE = 8'd132;
    localparam logic [7:0] TOUCHE_BAS = 8'd133;
    localparam logic [7:0] TOUCHE_ECHAP = 8'd140;
    localparam logic [7:0] TOUCHE_F1 = 8'd141;
    localparam logic [7:0] SC_SHIFT_G = 8'h12;
    localparam logic [7:0] SC_SHIFT_D = 8'h59;
    localparam logic [7:0] SC_VERR_MAJ = 8'h58;

    // Returns 8'h00 for anything that must not be queued.
    function automatic logic [7:0] traduire(input logic [7:0] code, input logic ext,
                                            input logic shift, input logic caps);
        logic [7:0] c;
        c = 8'h00;
        if (ext) begin
            case (code)
                8'h6B: c = TOUCHE_GAUCHE;
                8'h75: c = TOUCHE_HAUT;
                8'h74: c = TOUCHE_DROITE;
                8'h72: c = TOUCHE_BAS;
                8'h5A: c = TOUCHE_ENTREE;
                default: c = 8'h00;
            endcase
        end else begin
            case (code)
                8'h1C: c = "a"; 8'h32: c = "b"; 8'h21: c = "c"; 8'h23: c = "d";
                8'h24: c = "e"; 8'h2B: c = "f"; 8'h34: c = "g"; 8'h33: c = "h";
                8'h43: c = "i"; 8'h3B: c = "j"; 8'h42: c = "k"; 8'h4B: c = "l";
                8'h3A: c = "m"; 8'h31: c = "n"; 8'h44: c = "o"; 8'h4D: c = "p";
                8'h15: c = "q"; 8'h2D: c = "r"; 8'h1B: c = "s"; 8'h2C: c = "t";
                8'h3C: c = "u"; 8'h2A: c = "v"; 8'h1D: c = "w"; 8'h22: c = "x";
                8'h35: c = "y"; 8'h1A: c = "z";
                8'h16: c = shift ? "!" : "1";
                8'h1E: c = shift ? "@" : "2";
                8'h26: c = shift ? "#" : "3";
                8'h25: c = shift ? "$" : "4";
                8'h2E: c = shift ? "%" : "5";
                8'h36: c = shift ? "^" : "6";
                8'h3D: c = shift ? "&" : "7";
                8'h3E: c = shift ? "*" : "8";
                8'h46: c = shift ? "(" : "9";
                8'h45: c = shift ? ")" : "0";
                8'h29: c = " "; 8'h52: c = "'"; 8'h41: c = ","; 8'h4C: c = ";";
                8'h49: c = "."; 8'h4A: c = "/"; 8'h54: c = "["; 8'h5B: c = "]";
                8'h5D: c = "\\"; 8'h4E: c = "-"; 8'h55: c = "=";
                8'h79: c = "+"; 8'h7B: c = "-"; 8'h7C: c = "*";
                8'h5A: c = TOUCHE_ENTREE;
                8'h66: c = TOUCHE_RETOUR;
                8'h76: c = TOUCHE_ECHAP;
                8'h05: c = TOUCHE_F1;
                8'h06: c = TOUCHE_F1 + 8'd1;
                8'h04: c = TOUCHE_F1 + 8'd2;
                8'h0C: c = TOUCHE_F1 + 8'd3;
                8'h03: c = TOUCHE_F1 + 8'd4;
                8'h0B: c = TOUCHE_F1 + 8'd5;
                8'h83: c = TOUCHE_F1 + 8'd6;
                8'h0A: c = TOUCHE_F1 + 8'd7;
                8'h01: c = TOUCHE_F1 + 8'd8;
                8'h09: c = TOUCHE_F1 + 8'd9;
                8'h78: c = TOUCHE_F1 + 8'd10;
                8'h07: c = TOUCHE_F1 + 8'd11;
                default: c = 8'h00;
            endcase
            if ((shift ^ caps) && c >= "a" && c <= "z") c = c - 8'd32;
        end
        return c;
    endfunction
endpackage

// File: rtl/fifo_sync.sv
// fifo_sync: synchronous FIFO with a registered head output valid in the same cycle as ~vide.
module fifo_sync #(
    parameter int LARGEUR = 8,
    parameter int PROFONDEUR = 8
) (
    input  logic horloge_i,
    input  logic raz_i,
    input  logic push_i,
    input  logic pop_i,
    input  logic [LARGEUR-1:0] donnee_i,
    output logic [LARGEUR-1:0] donnee_o,
    output logic [$clog2(PROFONDEUR):0] niveau_o,
    output logic plein_o,
    output logic vide_o
);
    localparam int AW = $clog2(PROFONDEUR);
    localparam logic [AW:0] N_PLEIN = (AW + 1)'(PROFONDEUR);
    logic [LARGEUR-1:0] mem_q [PROFONDEUR];
    logic [LARGEUR-1:0] tete_q, tete_d;
    logic [AW:0] wr_q, rd_q, rd_d;
    logic push_ok, pop_ok;
    always_comb begin
        niveau_o = wr_q - rd_q;
        vide_o = niveau_o == '0;
        plein_o = niveau_o == N_PLEIN;
        pop_ok = pop_i & ~vide_o;
        push_ok = push_i & (~plein_o | pop_ok);
        rd_d = rd_q + (AW + 1)'(pop_ok);
        // The written word becomes the head when nothing else remains in front of it.
        tete_d = (push_ok && niveau_o == (AW + 1)'(pop_ok)) ? donnee_i : mem_q[rd_d[AW-1:0]];
    end
    always_ff @(posedge horloge_i) begin
        if (raz_i) begin
            wr_q <= '0;
            rd_q <= '0;
            tete_q <= '0;
        end else begin
            wr_q <= wr_q + (AW + 1)'(push_ok);
            rd_q <= rd_d;
            tete_q <= tete_d;
        end
    end
    always_ff @(posedge horloge_i) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= donnee_i;
    end
    assign donnee_o = tete_q;
endmodule

// File: rtl/clavier_fifo.sv
// clavier_fifo: PS/2 events -> translated characters queued toward a valid/ready consumer.
// Defining CLAVIER_REPETITION_EN adds held-key auto-repeat.
module clavier_fifo
    import clavier_pkg::*;
#(
    parameter int PROFONDEUR = 8,
    parameter int DELAI_REPETITION = 25000000,
    parameter int PERIODE_REPETITION = 2500000
) (
    input  logic horloge,
    input  logic raz,
    input  logic [10:0] clavier,
    output logic [7:0] car_out,
    output logic valide,
    input  logic pret,
    output logic [$clog2(PROFONDEUR):0] niveau,
    output logic debordement,
    output logic majuscule
);
    if (PROFONDEUR < 2 || PROFONDEUR > 256 || (PROFONDEUR & (PROFONDEUR - 1)) != 0 ||
        DELAI_REPETITION < 1 || PERIODE_REPETITION < 1) begin : g_parametres_invalides
        $error("clavier_fifo: parametres invalides");
    end
    logic bascule_q, ev_q, appui_q, ext_q;
    logic [7:0] code_q, car_q, car_d, trad;
    logic shift_g_q, shift_d_q, caps_q, push_q, push_d, debord_q;
    logic modif, push_ev, plein, vide;
    assign modif = ~ext_q & (code_q == SC_SHIFT_G | code_q == SC_SHIFT_D | code_q == SC_VERR_MAJ);
    assign trad = traduire(code_q, ext_q, shift_g_q | shift_d_q, caps_q);
`ifdef CLAVIER_REPETITION_EN
    localparam logic [31:0] DELAI = 32'(DELAI_REPETITION);
    localparam logic [31:0] PERIODE = 32'(PERIODE_REPETITION);
    logic rep_actif_q, rep_premier_q, rep_ext_q, rep_tir;
    logic [7:0] rep_code_q, rep_trad;
    logic [31:0] rep_cnt_q;
    assign rep_trad = traduire(rep_code_q, rep_ext_q, shift_g_q | shift_d_q, caps_q);
    assign rep_tir = rep_actif_q && rep_cnt_q == (rep_premier_q ? DELAI : PERIODE);
    // A new non-modifier press takes over the timer; only a release of the held key stops it.
    always_ff @(posedge horloge) begin
        if (raz) begin
            rep_actif_q <= 1'b0;
            rep_premier_q <= 1'b0;
            rep_ext_q <= 1'b0;
            rep_code_q <= 8'h00;
            rep_cnt_q <= 32'd0;
        end else if (ev_q && !modif && appui_q) begin
            rep_actif_q <= push_ev;
            rep_premier_q <= 1'b1;
            rep_ext_q <= ext_q;
            rep_code_q <= code_q;
            rep_cnt_q <= 32'd1;
        end else if (ev_q && !appui_q && ext_q == rep_ext_q && code_q == rep_code_q) begin
            rep_actif_q <= 1'b0;
        end else if (rep_tir) begin
            rep_premier_q <= 1'b0;
            rep_cnt_q <= 32'd1;
        end else if (rep_actif_q) begin
            rep_cnt_q <= rep_cnt_q + 32'd1;
        end
    end
`endif
    always_comb begin
        push_ev = ev_q & appui_q & ~modif & (trad != 8'h00);
`ifdef CLAVIER_REPETITION_EN
        push_d = push_ev | (rep_tir & (rep_trad != 8'h00));
        car_d = push_ev ? trad : rep_trad;
`else
        push_d = push_ev;
        car_d = trad;
`endif
    end
    always_ff @(posedge horloge) begin
        bascule_q <= clavier[10];
        if (raz) begin
            ev_q <= 1'b0;
            {appui_q, ext_q, code_q} <= '0;
            {shift_g_q, shift_d_q, caps_q} <= '0;
            push_q <= 1'b0;
            car_q <= 8'h00;
            debord_q <= 1'b0;
        end else begin
            ev_q <= clavier[10] ^ bascule_q;
            {appui_q, ext_q, code_q} <= clavier[9:0];
            push_q <= push_d;
            car_q <= car_d;
            if (ev_q && !ext_q && code_q == SC_SHIFT_G) shift_g_q <= appui_q;
            if (ev_q && !ext_q && code_q == SC_SHIFT_D) shift_d_q <= appui_q;
            if (ev_q && appui_q && !ext_q && code_q == SC_VERR_MAJ) caps_q <= ~caps_q;
            if (push_q && plein && !(pret && !vide)) debord_q <= 1'b1;
        end
    end
    fifo_sync #(.LARGEUR(8), .PROFONDEUR(PROFONDEUR)) u_fifo (
        .horloge_i(horloge),
        .raz_i(raz),
        .push_i(push_q),
        .pop_i(pret),
        .donnee_i(car_q),
        .donnee_o(car_out),
        .niveau_o(niveau),
        .plein_o(plein),
        .vide_o(vide)
    );
    assign valide = ~vide;
    assign debordement = debord_q;
    assign majuscule = (shift_g_q | shift_d_q) ^ caps_q;
endmodule
